program_loader: RTL and testbench

Upstream sequencer for the vector CPU. It receives a program as a byte stream from the host over a valid/ready handshake and packs each group of 4 bytes into a 32-bit instruction word. It writes those words into instruction memory, then issues the single-cycle `start` pulse to the CPU. It waits for the CPU's `EndFlag`, reports completion and the run length, and re-arms for the next program.

---
 rtl/loader_pkg.sv | 16 +
 rtl/byte_packer.sv | 72 +++++++
 rtl/program_loader.sv | 152 +++++++++++++++
 tb/tb_program_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, packing geometry
// and the default RUN watchdog limit.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } loader_state_t;

    localparam int          BYTES_PER_WORD  = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 32'd1 << 20;

endpackage

// File: rtl/byte_packer.sv
// Collects host bytes into big-endian instruction words; emits each finished word
// with a one-cycle wordValid in the cycle after its last byte is accepted.
module byte_packer
    import loader_pkg::*;
#(
    parameter int I = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [7:0]   byteData,
    input  logic         byteFire,
    output logic         lastByte,
    output logic [I-1:0] word,
    output logic         wordValid
);

    localparam int             CW      = $clog2(BYTES_PER_WORD);
    localparam logic [CW-1:0]  LastIdx = CW'(BYTES_PER_WORD - 1);

    logic [CW-1:0]                       countReg;
    logic [BYTES_PER_WORD-2:0][7:0]      laneReg;
    logic [I-1:0]                        wordReg;
    logic [I-1:0]                        wordNext;
    logic                                wordValidReg;

    assign lastByte = byteFire && (countReg == LastIdx);

    // Earlier bytes land in the upper lanes; the final byte bypasses storage.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : gLane
            assign wordNext[I-1-8*gi -: 8] = laneReg[gi];
        end
    endgenerate
    assign wordNext[7:0] = byteData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            laneReg <= '0;
        end else if (byteFire) begin
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (countReg == CW'(i)) begin
                    laneReg[i] <= byteData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg     <= '0;
            wordReg      <= '0;
            wordValidReg <= 1'b0;
        end else if (clear) begin
            countReg     <= '0;
            wordValidReg <= 1'b0;
        end else begin
            wordValidReg <= lastByte;
            if (byteFire) begin
                countReg <= countReg + 1'b1;
            end
            if (lastByte) begin
                wordReg <= wordNext;
            end
        end
    end

    assign word      = wordReg;
    assign wordValid = wordValidReg;

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, starts the CPU and times its run.
// Define PROGRAM_LOADER_TIMEOUT_EN to enable the RUN watchdog (limit TIMEOUT cycles).
module program_loader
    import loader_pkg::*;
#(
    parameter int          I       = 32,
    parameter int          AW      = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    input  logic [AW:0]   load_len,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [I-1:0]  imem_wdata,
    output logic          start,
    input  logic          EndFlag,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   run_cycles
);

    localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};

    loader_state_t stateReg, stateNext;
    logic          byteReadyReg, byteReadyNext;
    logic          startReg, busyReg, doneReg;
    logic          errReg, errNext;
    logic [AW:0]   lenReg, wordCountReg;
    logic [31:0]   runCyclesReg;

    logic          idleLike, lenOk, accept, reject;
    logic          byteFire, packLast, lastWord, lastFire;
    logic          wordValid, timeoutHit;
    logic [I-1:0]  word;

    assign idleLike = (stateReg == ST_IDLE) || (stateReg == ST_DONE);
    assign lenOk    = (load_len != '0) && (load_len <= MaxLen);
    assign accept   = idleLike && load_req && lenOk;
    assign reject   = idleLike && load_req && !lenOk;
    assign byteFire = byte_valid && byteReadyReg;

    // The word counter only advances on the write cycle, so during the final
    // word's bytes it already holds the index of that last word.
    assign lastWord = (wordCountReg == lenReg - 1'b1);
    assign lastFire = packLast && lastWord;

    byte_packer #(.I(I)) packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .byteData  (byte_data),
        .byteFire  (byteFire),
        .lastByte  (packLast),
        .word      (word),
        .wordValid (wordValid)
    );

    always_comb begin
        stateNext  = stateReg;
        timeoutHit = 1'b0;
        unique case (stateReg)
            ST_IDLE, ST_DONE: begin
                if (load_req) begin
                    stateNext = lenOk ? ST_LOAD : ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (wordValid && lastWord) begin
                    stateNext = ST_START;
                end
            end
            ST_START: stateNext = ST_RUN;
            ST_RUN: begin
                if (EndFlag) begin
                    stateNext = ST_DONE;
                end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
                else if (runCyclesReg == 32'(TIMEOUT - 1)) begin
                    stateNext  = ST_DONE;
                    timeoutHit = 1'b1;
                end
`endif
            end
            default: stateNext = ST_IDLE;
        endcase

        // Ready drops right after the program's final byte, before the last write.
        byteReadyNext = (stateNext == ST_LOAD) && !lastFire;

        errNext = errReg;
        if (accept) begin
            errNext = 1'b0;
        end else if (reject || timeoutHit) begin
            errNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg     <= ST_IDLE;
            byteReadyReg <= 1'b0;
            startReg     <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            errReg       <= 1'b0;
            lenReg       <= '0;
            wordCountReg <= '0;
            runCyclesReg <= '0;
        end else begin
            stateReg     <= stateNext;
            byteReadyReg <= byteReadyNext;
            startReg     <= (stateNext == ST_START);
            busyReg      <= (stateNext == ST_LOAD) || (stateNext == ST_START) ||
                            (stateNext == ST_RUN);
            doneReg      <= (stateNext == ST_DONE);
            errReg       <= errNext;

            if (accept) begin
                lenReg <= load_len;
            end

            if (accept) begin
                wordCountReg <= '0;
            end else if (wordValid) begin
                wordCountReg <= wordCountReg + 1'b1;
            end

            if (accept) begin
                runCyclesReg <= '0;
            end else if ((stateReg == ST_RUN) && (runCyclesReg != '1)) begin
                runCyclesReg <= runCyclesReg + 1'b1;
            end
        end
    end

    assign byte_ready = byteReadyReg;
    assign imem_we    = wordValid;
    assign imem_addr  = wordCountReg[AW-1:0];
    assign imem_wdata = word;
    assign start      = startReg;
    assign busy       = busyReg;
    assign done       = doneReg;
    assign err        = errReg;
    assign run_cycles = runCyclesReg;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random programs and host stalls checked
// against a memory image and timing model computed in the bench.
module tb_program_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic [AW:0]   load_len = '0;
    logic [7:0]    byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          EndFlag = 1'b0;
    logic          byte_ready, imem_we, start, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata, run_cycles;

    program_loader #(.I(32), .AW(AW), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .load_len   (load_len),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .EndFlag    (EndFlag),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int startCount = 0;
    int lastCyc = 0;
    int startCyc = 0;
    logic [AW-1:0] capAddr[$];
    logic [31:0]   capData[$];
    logic [7:0]    prog[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            capAddr.push_back(imem_addr);
            capData.push_back(imem_wdata);
        end
        if (start === 1'b1) startCount++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic make_prog(input int len, input bit fixedPattern);
        logic [7:0] pat [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        prog.delete();
        for (int i = 0; i < 4 * len; i++) begin
            if (fixedPattern) prog.push_back(pat[i % 8]);
            else prog.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic issue_load(input int len);
        load_req = 1'b1;
        load_len = (AW+1)'(len);
        step();
        load_req = 1'b0;
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %0b expected 1", byte_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %0b expected 1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err_clear: got %0b expected 0", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_clear: got %0b expected 0", done); end
        checks++; if (run_cycles !== 32'd0) begin errors++; $display("FAIL load_run_clear: got %0d expected 0", run_cycles); end
    endtask

    task automatic send_bytes(input int first, input int n, input int gapMax);
        for (int i = first; i < first + n; i++) begin
            int gaps;
            bit accepted;
            gaps = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
            byte_valid = 1'b0;
            repeat (gaps) step();
            byte_data  = prog[i];
            byte_valid = 1'b1;
            accepted   = 1'b0;
            for (int t = 0; t < 64 && !accepted; t++) begin
                if (byte_ready === 1'b1) begin
                    accepted = 1'b1;
                    lastCyc  = cyc;
                end
                step();
            end
            checks++; if (!accepted) begin errors++; $display("FAIL byte_accept: byte %0d got not accepted expected accepted", i); end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        for (int t = 0; t < 16 && !found; t++) begin
            if (start === 1'b1) begin
                found    = 1'b1;
                startCyc = cyc;
            end else begin
                step();
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL start_seen: got no start expected start pulse"); end
    endtask

    task automatic check_image(input int len);
        checks++; if (capData.size() != len) begin errors++; $display("FAIL write_count: got %0d expected %0d", capData.size(), len); end
        for (int k = 0; k < len && k < capData.size(); k++) begin
            logic [31:0] expWord;
            expWord = (32'(prog[4*k]) << 24) | (32'(prog[4*k+1]) << 16) |
                      (32'(prog[4*k+2]) << 8) | 32'(prog[4*k+3]);
            checks++; if (capAddr[k] !== AW'(k)) begin errors++; $display("FAIL write_addr: got %0d expected %0d", capAddr[k], k); end
            checks++; if (capData[k] !== expWord) begin errors++; $display("FAIL write_data[%0d]: got %08h expected %08h", k, capData[k], expWord); end
        end
    endtask

    task automatic load_program(input int len, input int gapMax, input bit fixedPattern);
        int sc0;
        make_prog(len, fixedPattern);
        capAddr.delete();
        capData.delete();
        sc0 = startCount;
        issue_load(len);
        send_bytes(0, 4 * len, gapMax);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL ready_after_last: got %0b expected 0", byte_ready); end
        wait_start();
        checks++; if (startCyc != lastCyc + 2) begin errors++; $display("FAIL start_latency: got %0d expected %0d", startCyc - lastCyc, 2); end
        step();
        byte_valid = 1'b0;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_width: got %0b expected 0", start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %0b expected 1", busy); end
        checks++; if (startCount != sc0 + 1) begin errors++; $display("FAIL start_count: got %0d expected %0d", startCount - sc0, 1); end
        check_image(len);
        $display("load len=%0d gapMax=%0d writes=%0d start_cycle=%0d", len, gapMax, capData.size(), startCyc);
    endtask

    // Called at cycle startCyc+1; EndFlag is presented in cycle startCyc+delay.
    task automatic finish_run(input int delay);
        repeat (delay - 1) step();
        EndFlag = 1'b1;
        step();
        EndFlag = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done: got %0b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_not_busy: got %0b expected 0", busy); end
        checks++; if (run_cycles !== 32'(delay)) begin errors++; $display("FAIL run_cycles: got %0d expected %0d", run_cycles, delay); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL run_err: got %0b expected 0", err); end
        $display("run end_delay=%0d run_cycles=%0d done=%0b", delay, run_cycles, done);
    endtask

    task automatic test_reset();
        step();
        checks++; if ({byte_ready, imem_we, start, busy, done, err} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %06b expected 000000", {byte_ready, imem_we, start, busy, done, err}); end
        checks++; if ({imem_addr, imem_wdata, run_cycles} !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", {imem_addr, imem_wdata, run_cycles}); end
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_length_check();
        int badLens [2] = '{0, 257};
        foreach (badLens[i]) begin
            load_req = 1'b1;
            load_len = (AW+1)'(badLens[i]);
            step();
            load_req = 1'b0;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL badlen_err len=%0d: got %0b expected 1", badLens[i], err); end
            checks++; if (byte_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL badlen_idle len=%0d: got ready=%0b busy=%0b expected 0 0", badLens[i], byte_ready, busy); end
            step();
        end
        load_program(256, 0, 1'b0);
        finish_run($urandom_range(1, 12));
    endtask

    task automatic test_two_word();
        load_program(2, 0, 1'b1);
        finish_run(10);
    endtask

    task automatic test_stalls();
        load_program(2, 4, 1'b1);
        finish_run($urandom_range(1, 12));
        repeat (3) begin
            load_program($urandom_range(1, 6), 3, 1'b0);
            finish_run($urandom_range(1, 12));
        end
    endtask

    task automatic test_run_restart();
        int d;
        int sc0;
        d = $urandom_range(2, 14);
        load_program(1, 0, 1'b0);
        finish_run(d);
        repeat (3) step();
        checks++; if (done !== 1'b1 || run_cycles !== 32'(d)) begin errors++; $display("FAIL done_hold: got done=%0b run=%0d expected 1 %0d", done, run_cycles, d); end
        load_program(1, 1, 1'b0);
        finish_run(3);
        load_req = 1'b1;
        load_len = '0;
        step();
        load_req = 1'b0;
        checks++; if (done !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL done_badlen: got done=%0b err=%0b expected 0 1", done, err); end
        sc0 = startCount;
        EndFlag = 1'b1;
        step();
        EndFlag = 1'b0;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || startCount != sc0) begin errors++; $display("FAIL endflag_idle: got done=%0b busy=%0b starts=%0d expected 0 0 0", done, busy, startCount - sc0); end
    endtask

    task automatic test_reset_mid();
        make_prog(3, 1'b0);
        issue_load(3);
        send_bytes(0, 5, 0);
        reset = 1'b0;
        #1;
        checks++; if ({byte_ready, imem_we, start, busy, done, err} !== 6'b0) begin errors++; $display("FAIL midreset_flags: got %06b expected 000000", {byte_ready, imem_we, start, busy, done, err}); end
        checks++; if ({imem_addr, imem_wdata, run_cycles} !== '0) begin errors++; $display("FAIL midreset_data: got %0h expected 0", {imem_addr, imem_wdata, run_cycles}); end
        step();
        step();
        reset = 1'b1;
        step();
        load_program(3, 2, 1'b0);
        finish_run(5);
    endtask

    task automatic test_watchdog();
`ifdef PROGRAM_LOADER_TIMEOUT_EN
        load_program(1, 0, 1'b0);
        repeat (16) step();
        checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL wd_expire: got done=%0b err=%0b expected 1 1", done, err); end
        checks++; if (run_cycles !== 32'd16) begin errors++; $display("FAIL wd_cycles: got %0d expected 16", run_cycles); end
        load_program(1, 0, 1'b0);
        finish_run(16);
`else
        load_program(1, 0, 1'b0);
        repeat (39) step();
        checks++; if (done !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL no_wd_wait: got done=%0b busy=%0b err=%0b expected 0 1 0", done, busy, err); end
        checks++; if (run_cycles !== 32'd39) begin errors++; $display("FAIL no_wd_cycles: got %0d expected 39", run_cycles); end
        EndFlag = 1'b1;
        step();
        EndFlag = 1'b0;
        checks++; if (done !== 1'b1 || run_cycles !== 32'd40) begin errors++; $display("FAIL no_wd_end: got done=%0b run=%0d expected 1 40", done, run_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_length_check();
        test_two_word();
        test_stalls();
        test_run_restart();
        test_reset_mid();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
